uart_rx_ctrl: RTL and testbench

- Receive-side sequencer for the serial link.
- Detects the start bit and gates the external 4-bit bit-sampling counter (bitProgress, 16 clocks per bit).
- Samples rxd at mid-bit, assembles a DATA_BITS character LSB-first and checks the stop bit.
- Presents the character to the consumer on a valid/ready handshake; sits between the rx pin and the character buffer.

---
 rtl/uart_rx_ctrl.sv | 116 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive sequencer for a 16x-oversampled serial line: start detect, mid-bit
// sampling via an external bit-sampling counter, stop check and valid/ready output.
module uart_rx_ctrl #(
  parameter int         DATA_BITS = 8,
  parameter logic [3:0] MID       = 4'd7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [3:0]           bitProgress,
  output logic                 bscEnable,
  output logic                 bscClear,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 dataValid,
  input  logic                 dataReady,
  output logic                 framingError,
  output logic                 overrun
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t               state_reg;
  logic [1:0]           sync_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_count_reg;

  logic                 rxd_s;
  logic                 at_mid;
  logic [DATA_BITS:0]   shift_wide;
  logic [DATA_BITS-1:0] shift_next;

  assign rxd_s      = sync_reg[1];
  assign at_mid     = (bitProgress == MID);
  // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
  assign shift_wide = {rxd_s, shift_reg};
  assign shift_next = shift_wide[DATA_BITS:1];

  assign bscEnable = (state_reg == ST_START) || (state_reg == ST_DATA) || (state_reg == ST_STOP);
  assign bscClear  = !bscEnable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      sync_reg      <= 2'b11;
      shift_reg     <= '0;
      bit_count_reg <= '0;
      dataOut       <= '0;
      dataValid     <= 1'b0;
      framingError  <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], rxd};
      framingError <= 1'b0;
      overrun      <= 1'b0;
      if (dataValid && dataReady) begin
        dataValid <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_reg <= ST_START;
          end
        end
        ST_START: begin
          if (at_mid) begin
            if (!rxd_s) begin
              state_reg     <= ST_DATA;
              bit_count_reg <= '0;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (at_mid) begin
            shift_reg     <= shift_next;
            bit_count_reg <= bit_count_reg + 3'd1;
            if (bit_count_reg == LAST_BIT) begin
              state_reg <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (at_mid) begin
            if (rxd_s) begin
              // A load overrides the handshake clear issued above in the same cycle.
              dataOut   <= shift_reg;
              dataValid <= 1'b1;
              overrun   <= dataValid && !dataReady;
              state_reg <= ST_IDLE;
            end else begin
              framingError <= 1'b1;
              state_reg    <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_s) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized frames for uart_rx_ctrl, checked against a
// frame-level model of the expected character, valid flag and pulses.
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [3:0] bitProgress;
  logic       bscEnable;
  logic       bscClear;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       dataReady;
  logic       framingError;
  logic       overrun;

  int checks = 0;
  int passed = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int cyc    = 0;

  // Model of the consumer-visible holding register.
  bit         pend = 0;
  logic [7:0] pend_data = '0;

  uart_rx_ctrl #(.DATA_BITS(8), .MID(4'd7)) dut (
    .clk          (clk),
    .rst          (rst),
    .rxd          (rxd),
    .bitProgress  (bitProgress),
    .bscEnable    (bscEnable),
    .bscClear     (bscClear),
    .dataOut      (dataOut),
    .dataValid    (dataValid),
    .dataReady    (dataReady),
    .framingError (framingError),
    .overrun      (overrun)
  );

  // Bit-sampling counter: clear wins, otherwise counts while enabled.
  always_ff @(posedge clk) begin
    if (bscClear || !rst) bitProgress <= 4'd0;
    else if (bscEnable)   bitProgress <= bitProgress + 4'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (framingError === 1'b1) fe_cnt = fe_cnt + 1;
    if (overrun === 1'b1)      ov_cnt = ov_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  task automatic accept();
    @(negedge clk);
    dataReady = 1'b1;
    @(negedge clk);
    dataReady = 1'b0;
    chk("accept_clears", dataValid, 0);
    pend = 0;
  endtask

  // mode 0: dataReady low; 1: dataReady high all frame; 2: dataReady pulsed on the stop-sample cycle.
  // Index j counts negedges from the one that drives the start bit; the stop
  // sample edge is 2 (sync) + 8 + 16*9 = 154 edges after that drive.
  task automatic send_frame(input logic [7:0] d, input bit stop, input int mode,
                            input int extra, input int abort_at);
    logic [9:0] bits;
    int  fe0;
    int  ov0;
    bit  exp_ov;
    bits   = {stop, d, 1'b0};
    fe0    = fe_cnt;
    ov0    = ov_cnt;
    exp_ov = 0;
    for (int j = 0; j < 160 + extra; j++) begin
      @(negedge clk);
      if (j == abort_at) return;
      if (j == 0) begin
        dataReady = (mode == 1);
        if (mode == 1) pend = 0;
      end
      if (j == 154) chk("valid_before_stop", dataValid, pend);
      if (j == 155) begin
        if (stop) begin
          exp_ov = pend && (mode == 0);
          chk("valid_load", dataValid, 1);
          chk("data_load", dataOut, d);
          chk("overrun_pulse", overrun, exp_ov);
          pend = 1;
          pend_data = d;
        end else begin
          chk("framing_pulse", framingError, 1);
          chk("valid_hold", dataValid, (mode == 2) ? 0 : pend);
          if (pend) chk("data_hold", dataOut, pend_data);
          if (mode == 2) pend = 0;
        end
      end
      if (j == 156 && mode != 0) chk("valid_after_accept", dataValid, (mode == 2 && stop) ? 1 : 0);
      if (mode == 2) dataReady = (j == 154);
      rxd = (j < 160) ? bits[j/16] : stop;
    end
    if (mode == 1) pend = 0;
    dataReady = 1'b0;
    chk("fe_count", fe_cnt - fe0, stop ? 0 : 1);
    chk("ov_count", ov_cnt - ov0, exp_ov);
  endtask

  initial begin
    int fe0;
    int ov0;
    logic [7:0] d;
    bit st;
    int md;

    rst = 1'b0;
    rxd = 1'b1;
    dataReady = 1'b0;
    #12;
    chk("rst_bscEnable", bscEnable, 0);
    chk("rst_bscClear", bscClear, 1);
    chk("rst_dataOut", dataOut, 0);
    chk("rst_dataValid", dataValid, 0);
    chk("rst_framingError", framingError, 0);
    chk("rst_overrun", overrun, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(10);

    // Basic frame with consumer stalled, then single-cycle accept.
    send_frame(8'hA5, 1, 0, 0, -1);
    accept();

    // Short low glitch: START aborts at its mid-bit sample.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (j == 3) begin
        chk("glitch_start_en", bscEnable, 1);
        chk("glitch_start_cnt", bitProgress, 0);
      end
      if (j == 10) chk("glitch_still_start", bscEnable, 1);
      if (j == 11) begin
        chk("glitch_back_idle_en", bscEnable, 0);
        chk("glitch_back_idle_clr", bscClear, 1);
      end
      rxd = (j < 3) ? 1'b0 : 1'b1;
    end
    chk("glitch_valid", dataValid, 0);
    chk("glitch_fe", fe_cnt - fe0, 0);
    chk("glitch_ov", ov_cnt - ov0, 0);

    // Framing error with a long break, then recovery.
    send_frame(8'h3C, 0, 0, 40, -1);
    chk("break_no_valid", dataValid, 0);
    idle(10);
    send_frame(8'h01, 1, 0, 0, -1);
    accept();

    // Back-to-back frames without acceptance: second one overruns.
    send_frame(8'h55, 1, 0, 0, -1);
    send_frame(8'h0F, 1, 0, 0, -1);
    // Acceptance on the very cycle a new character loads.
    send_frame(8'h6B, 1, 2, 0, -1);
    accept();

    // Asynchronous reset mid data bit 4 with a character pending.
    send_frame(8'h33, 1, 0, 0, -1);
    send_frame(8'hFF, 1, 0, 0, 88);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_bscEnable", bscEnable, 0);
    chk("arst_bscClear", bscClear, 1);
    chk("arst_dataValid", dataValid, 0);
    chk("arst_dataOut", dataOut, 0);
    rxd = 1'b1;
    pend = 0;
    #14;
    rst = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    idle(200);
    chk("post_rst_valid", dataValid, 0);
    chk("post_rst_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    send_frame(8'h81, 1, 0, 0, -1);
    accept();

    // Randomized frames, stop bits and consumer behaviour.
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 2);
      send_frame(d, st, md, 0, -1);
      idle(st ? $urandom_range(0, 3) : 4 + $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
